// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed scan controller for a bank of
// common-segment seven-segment digits. One shared hex decoder, one
// active-low enable per digit, frame-aligned word commits, leading-zero
// blanking and frame-based blink.

// Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
module sseg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  // Pure lookup; the caller registers the result.
  always_comb begin
    o_segs = 7'h7F;
    case (i_nibble)
      4'h0: o_segs = 7'b1000000;
      4'h1: o_segs = 7'b1111001;
      4'h2: o_segs = 7'b0100100;
      4'h3: o_segs = 7'b0110000;
      4'h4: o_segs = 7'b0011001;
      4'h5: o_segs = 7'b0010010;
      4'h6: o_segs = 7'b0000010;
      4'h7: o_segs = 7'b1111000;
      4'h8: o_segs = 7'b0000000;
      4'h9: o_segs = 7'b0010000;
      4'hA: o_segs = 7'b0001000;
      4'hB: o_segs = 7'b0000011;
      4'hC: o_segs = 7'b1000110;
      4'hD: o_segs = 7'b0100001;
      4'hE: o_segs = 7'b0000110;
      4'hF: o_segs = 7'b0001110;
      default: o_segs = 7'h7F;
    endcase
  end

endmodule

module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic                    wr_blank_lz,
  input  logic                    blink_en,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [6:0]              segs,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_t;

  // State and datapath registers
  state_t          r_state;
  logic [DW-1:0]   r_disp;
  logic            r_disp_lz;
  logic [DW-1:0]   r_shadow;
  logic            r_shadow_lz;
  logic            r_pend;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bcnt;
  logic            r_phase;
  logic [NUM_DIGITS-1:0] r_digit_en_n;
  logic [6:0]      r_segs;
  logic            r_frame_done;

  // Next-state values
  state_t          w_state_next;
  logic [DW-1:0]   w_disp_next;
  logic            w_disp_lz_next;
  logic [DW-1:0]   w_shadow_next;
  logic            w_shadow_lz_next;
  logic            w_pend_next;
  logic [IW-1:0]   w_idx_next;
  logic [CW-1:0]   w_cnt_next;
  logic [BW-1:0]   w_bcnt_next;
  logic            w_phase_next;

  // Output pipeline: decoded from next-state so enable and pattern share an edge
  logic [3:0]            w_nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic [3:0]            w_nib;
  logic [6:0]            w_dec;
  logic                  w_lz_blank;
  logic                  w_blank;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_en_n_next;
  logic [6:0]            w_segs_next;
  logic                  w_frame_done_next;
  logic                  w_accept;

  assign wr_ready   = ~r_pend;
  assign w_accept   = wr_valid & ~r_pend;
  assign digit_en_n = r_digit_en_n;
  assign segs       = r_segs;
  assign frame_done = r_frame_done;

  // Per-digit nibble slices and "this digit and everything above is zero" flags
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibs[gi]       = w_disp_next[4*gi +: 4];
      assign w_upper_zero[gi] = ~|w_disp_next[DW-1:4*gi];
      assign w_en_n_next[gi]  = ~(w_lit && (w_idx_next == IW'(gi)));
    end
  endgenerate

  assign w_nib = w_nibs[w_idx_next];

  sseg u_sseg (
    .i_nibble (w_nib),
    .o_segs   (w_dec)
  );

  // Next-state logic: scan sequencing, handshake, frame-end commit and blink
  always_comb begin
    w_state_next     = r_state;
    w_disp_next      = r_disp;
    w_disp_lz_next   = r_disp_lz;
    w_shadow_next    = r_shadow;
    w_shadow_lz_next = r_shadow_lz;
    w_pend_next      = r_pend;
    w_idx_next       = r_idx;
    w_cnt_next       = r_cnt;
    w_bcnt_next      = r_bcnt;
    w_phase_next     = r_phase;

    case (r_state)
      IDLE: begin
        // Nothing is on screen yet, so the word goes straight to disp
        if (w_accept) begin
          w_disp_next    = wr_data;
          w_disp_lz_next = wr_blank_lz;
          w_idx_next     = '0;
          w_cnt_next     = '0;
          w_state_next   = SCAN;
        end
      end

      SCAN: begin
        if (w_accept) begin
          w_shadow_next    = wr_data;
          w_shadow_lz_next = wr_blank_lz;
          w_pend_next      = 1'b1;
        end
        if (r_cnt == CNT_MAX) begin
          w_cnt_next   = '0;
          w_state_next = GAP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      GAP: begin
        if (w_accept) begin
          w_shadow_next    = wr_data;
          w_shadow_lz_next = wr_blank_lz;
          w_pend_next      = 1'b1;
        end
        w_cnt_next   = '0;
        w_state_next = SCAN;
        if (r_idx == LAST_IDX) begin
          // Frame end: commit pending word (accept is impossible while pending)
          w_idx_next = '0;
          if (r_pend) begin
            w_disp_next    = r_shadow;
            w_disp_lz_next = r_shadow_lz;
            w_pend_next    = 1'b0;
          end
          if (r_bcnt == BCNT_MAX) begin
            w_bcnt_next  = '0;
            w_phase_next = ~r_phase;
          end else begin
            w_bcnt_next = r_bcnt + 1'b1;
          end
          if (!blink_en) begin
            w_phase_next = 1'b0;
          end
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output decode for the cycle about to start
  always_comb begin
    w_lz_blank        = w_disp_lz_next && (w_idx_next != '0) && w_upper_zero[w_idx_next];
    w_blank           = w_lz_blank || (blink_en && w_phase_next);
    w_lit             = (w_state_next == SCAN) && !w_blank;
    w_segs_next       = w_lit ? w_dec : 7'h7F;
    w_frame_done_next = (w_state_next == GAP) && (w_idx_next == LAST_IDX);
  end

  // State, datapath and registered outputs; reset blanks the display at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_disp       <= '0;
      r_disp_lz    <= 1'b0;
      r_shadow     <= '0;
      r_shadow_lz  <= 1'b0;
      r_pend       <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
      r_digit_en_n <= '1;
      r_segs       <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_disp       <= w_disp_next;
      r_disp_lz    <= w_disp_lz_next;
      r_shadow     <= w_shadow_next;
      r_shadow_lz  <= w_shadow_lz_next;
      r_pend       <= w_pend_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_bcnt       <= w_bcnt_next;
      r_phase      <= w_phase_next;
      r_digit_en_n <= w_en_n_next;
      r_segs       <= w_segs_next;
      r_frame_done <= w_frame_done_next;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2. Inputs change and outputs are sampled on the falling edge.
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        resetn;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        wr_blank_lz;
  logic        blink_en;
  logic [3:0]  digit_en_n;
  logic [6:0]  segs;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  sseg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_blank_lz (wr_blank_lz),
    .blink_en    (blink_en),
    .digit_en_n  (digit_en_n),
    .segs        (segs),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        lz;
    logic [3:0]  en;
    logic [6:0]  segs;
    logic        ready;
    logic        fd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low patterns for the hex digits, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Position within a 20-cycle frame: pos/5 is the digit, pos%5==4 is the gap
  function automatic logic hidden(input logic [15:0] w, input logic lz, input logic dark, input int pos);
    int d = pos / 5;
    if (dark) return 1'b1;
    return lz && (d != 0) && ((w >> (4 * d)) == 16'h0);
  endfunction

  function automatic logic [3:0] exp_en(input logic [15:0] w, input logic lz, input logic dark, input int pos);
    logic [3:0] m;
    if ((pos % 5) == 4 || hidden(w, lz, dark, pos)) return 4'hF;
    m = 4'b0001 << (pos / 5);
    return ~m;
  endfunction

  function automatic logic [6:0] exp_segs(input logic [15:0] w, input logic lz, input logic dark, input int pos);
    logic [15:0] sh;
    if ((pos % 5) == 4 || hidden(w, lz, dark, pos)) return 7'h7F;
    sh = w >> (4 * (pos / 5));
    return seg_of(sh[3:0]);
  endfunction

  // Check n consecutive cycles of a frame starting at position start
  task automatic run_check(input logic [15:0] w, input logic lz, input logic dark,
                           input int start, input int n, input logic rdy, input string tag);
    int pos;
    for (int i = 0; i < n; i++) begin
      pos = (start + i) % 20;
      chk({tag, "_en"},    16'(digit_en_n), 16'(exp_en(w, lz, dark, pos)));
      chk({tag, "_segs"},  16'(segs),       16'(exp_segs(w, lz, dark, pos)));
      chk({tag, "_fd"},    16'(frame_done), 16'(pos == 19));
      chk({tag, "_ready"}, 16'(wr_ready),   16'(rdy));
      @(negedge clk);
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_en"},    16'(digit_en_n), 16'h000F);
    chk({tag, "_segs"},  16'(segs),       16'h007F);
    chk({tag, "_fd"},    16'(frame_done), 16'h0000);
    chk({tag, "_ready"}, 16'(wr_ready),   16'h0001);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    wr_valid = 1'b0;
    blink_en = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // One handshake from IDLE; returns at the first lit cycle
  task automatic load(input logic [15:0] d, input logic lz);
    wr_valid    = 1'b1;
    wr_data     = d;
    wr_blank_lz = lz;
    $display("write %h lz=%0d", d, lz);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic add_vec(input int n, input logic valid, input logic [3:0] en,
                         input logic [6:0] sg, input logic fd);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.valid = valid; v.data = 16'h1234; v.lz = 1'b0;
      v.en = en; v.segs = sg; v.ready = 1'b1; v.fd = fd;
      vq.push_back(v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = 16'h0;
    wr_blank_lz = 1'b0;
    blink_en    = 1'b0;

    // Test 1 trace: IDLE load of 1234, one full frame plus the next digit 0
    add_vec(1, 1'b1, 4'b1110, 7'b0011001, 1'b0);
    add_vec(3, 1'b0, 4'b1110, 7'b0011001, 1'b0);
    add_vec(1, 1'b0, 4'b1111, 7'h7F,      1'b0);
    add_vec(4, 1'b0, 4'b1101, 7'b0110000, 1'b0);
    add_vec(1, 1'b0, 4'b1111, 7'h7F,      1'b0);
    add_vec(4, 1'b0, 4'b1011, 7'b0100100, 1'b0);
    add_vec(1, 1'b0, 4'b1111, 7'h7F,      1'b0);
    add_vec(4, 1'b0, 4'b0111, 7'b1111001, 1'b0);
    add_vec(1, 1'b0, 4'b1111, 7'h7F,      1'b1);
    add_vec(1, 1'b0, 4'b1110, 7'b0011001, 1'b0);

    do_reset();
    // Reset state: dark, ready, no frame_done
    for (int i = 0; i < 3; i++) begin
      check_dark("reset");
      @(negedge clk);
    end

    $display("write 1234 lz=0 (table)");
    foreach (vq[i]) begin
      wr_valid    = vq[i].valid;
      wr_data     = vq[i].data;
      wr_blank_lz = vq[i].lz;
      @(negedge clk);
      chk($sformatf("t1_en[%0d]", i),    16'(digit_en_n), 16'(vq[i].en));
      chk($sformatf("t1_segs[%0d]", i),  16'(segs),       16'(vq[i].segs));
      chk($sformatf("t1_ready[%0d]", i), 16'(wr_ready),   16'(vq[i].ready));
      chk($sformatf("t1_fd[%0d]", i),    16'(frame_done), 16'(vq[i].fd));
    end
    wr_valid = 1'b0;

    // Test 2: mid-frame write, then a second write held during pend
    do_reset();
    load(16'h1234, 1'b0);
    run_check(16'h1234, 1'b0, 1'b0, 0, 5, 1'b1, "t2_pre");
    wr_valid = 1'b1;
    wr_data  = 16'hABCD;
    $display("write ABCD mid-frame");
    run_check(16'h1234, 1'b0, 1'b0, 5, 1, 1'b1, "t2_acc");
    wr_data  = 16'h5678;
    $display("write 5678 held valid while pending");
    run_check(16'h1234, 1'b0, 1'b0, 6, 14, 1'b0, "t2_old");
    run_check(16'hABCD, 1'b0, 1'b0, 0, 1, 1'b1, "t2_new0");
    wr_valid = 1'b0;
    run_check(16'hABCD, 1'b0, 1'b0, 1, 19, 1'b0, "t2_new");
    run_check(16'h5678, 1'b0, 1'b0, 0, 20, 1'b1, "t2_second");

    // Test 3: leading-zero blanking
    do_reset();
    load(16'h0005, 1'b1);
    run_check(16'h0005, 1'b1, 1'b0, 0, 20, 1'b1, "t3_0005");
    do_reset();
    load(16'h0000, 1'b1);
    run_check(16'h0000, 1'b1, 1'b0, 0, 20, 1'b1, "t3_0000");

    // Test 4: blink with two-frame half-period
    do_reset();
    blink_en = 1'b1;
    load(16'h1234, 1'b0);
    for (int f = 0; f < 6; f++) begin
      run_check(16'h1234, 1'b0, (f == 2 || f == 3), 0, 20, 1'b1, $sformatf("t4_f%0d", f));
    end
    blink_en = 1'b0;

    // Test 5: reset during digit-2 slot with a word pending
    do_reset();
    load(16'h1234, 1'b0);
    run_check(16'h1234, 1'b0, 1'b0, 0, 5, 1'b1, "t5_pre");
    wr_valid = 1'b1;
    wr_data  = 16'hABCD;
    $display("write ABCD then reset");
    run_check(16'h1234, 1'b0, 1'b0, 5, 1, 1'b1, "t5_acc");
    wr_valid = 1'b0;
    run_check(16'h1234, 1'b0, 1'b0, 6, 5, 1'b0, "t5_pend");
    #2 resetn = 1'b0;
    #1 check_dark("t5_inreset");
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_dark("t5_after");
    end
    load(16'h0F0F, 1'b0);
    run_check(16'h0F0F, 1'b0, 1'b0, 0, 20, 1'b1, "t5_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
